// File: rtl/pc_step_ctrl_pkg.sv
// Shared types and constants for the PC step controller.
package pc_step_ctrl_pkg;

  // Wide enough for any DB_CYCLES in 1..255.
  localparam int DB_CNT_W = $clog2(256);

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_HALT         = 2'd3
  } state_e;

endpackage

// File: rtl/pc_step_ctrl_sw_debounce.sv
// Push-button synchroniser and optional debouncer.
// The debounce counter exists only when PC_STEP_CTRL_DEBOUNCE_EN is defined.
import pc_step_ctrl_pkg::*;

module sw_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_db
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sw_in;
      s2_q <= s1_q;
    end
  end

`ifdef PC_STEP_CTRL_DEBOUNCE_EN
  logic                db_q, db_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Level flips on the DB_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == DB_CNT_W'(DB_CYCLES - 1)) begin
        db_d  = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign sw_db = db_q;
`else
  assign sw_db = s2_q;
`endif

endmodule

// File: rtl/pc_step_ctrl.sv
// Program-counter step controller: run / wait-for-switch handshake / halt.
// Define PC_STEP_CTRL_DEBOUNCE_EN to debounce the switch over DB_CYCLES.
import pc_step_ctrl_pkg::*;

module pc_step_ctrl #(
  parameter int P_SIZE    = 6,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [P_SIZE-1:0] pc_in,
  input  logic              wait_req,
  input  logic              halt_req,
  input  logic              sw_in,
  output logic              PCincr,
  output logic              stalled,
  output logic              halted,
  output logic              sw_ack,
  output logic [P_SIZE-1:0] halt_pc
);

  state_e            st_q, st_d;
  logic [P_SIZE-1:0] hpc_q, hpc_d;
  logic              sw_db;

  sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_sw_debounce (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .sw_db (sw_db)
  );

  always_comb begin
    st_d   = st_q;
    hpc_d  = hpc_q;
    PCincr = 1'b0;
    sw_ack = 1'b0;
    if (!reset) begin
      unique case (st_q)
        ST_RUN: begin
          PCincr = !wait_req && !halt_req;
          if (halt_req) begin
            st_d  = ST_HALT;
            hpc_d = pc_in;
          end else if (wait_req) begin
            st_d = ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (sw_db) st_d = ST_WAIT_RELEASE;
        end
        // Release completes the handshake: step past the wait exactly once.
        ST_WAIT_RELEASE: begin
          if (!sw_db) begin
            PCincr = 1'b1;
            sw_ack = 1'b1;
            st_d   = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= ST_RUN;
      hpc_q <= '0;
    end else begin
      st_q  <= st_d;
      hpc_q <= hpc_d;
    end
  end

  assign stalled = !reset && ((st_q == ST_WAIT_PRESS) || (st_q == ST_WAIT_RELEASE));
  assign halted  = !reset && (st_q == ST_HALT);
  assign halt_pc = hpc_q;

endmodule
